// File: rtl/host_cmd_parser.sv
// host_cmd_parser: drains host SPI RX bytes, decodes CMD/LEN packets into register-bus writes and reads, and returns read data to the host TX FIFO.
// Latency: write strobe on the cycle after the RX pop; read data pushed to TX one cycle after reg_rd_en; at most 1 RX byte per 2 cycles.
// Backpressure: waits indefinitely on rx_fifo_empty; issues no read while tx_fifo_full. Optional trailing checksum: HOST_CMD_CKSUM_EN.
module host_cmd_parser (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_fifo_empty,
    output logic       rx_fifo_rd_en,
    input  logic [7:0] rx_fifo_dout,
    input  logic       tx_fifo_full,
    output logic       tx_fifo_wr_en,
    output logic [7:0] tx_fifo_din,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err_cksum,
    input  logic       err_clr
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RREQ  = 3'd3,
`ifdef HOST_CMD_CKSUM_EN
        ST_RWAIT = 3'd4,
        ST_CKSUM = 3'd5
`else
        ST_RWAIT = 3'd4
`endif
    } state_t;

    // Where the parser goes once the header / write data is finished.
`ifdef HOST_CMD_CKSUM_EN
    localparam state_t ST_AFTER_ZERO = ST_CKSUM;
    localparam state_t ST_AFTER_RHDR = ST_CKSUM;
    localparam state_t ST_AFTER_WR   = ST_CKSUM;
`else
    localparam state_t ST_AFTER_ZERO = ST_IDLE;
    localparam state_t ST_AFTER_RHDR = ST_RREQ;
    localparam state_t ST_AFTER_WR   = ST_IDLE;
`endif

    state_t     state_q, state_d;
    logic       pend_q;
    logic       byte_vld;
    logic       need_byte;
    logic       is_wr_q, is_wr_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wr_stb, rd_stb, push_stb;

    // A popped byte is presented by the FIFO one cycle later.
    assign byte_vld = pend_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Packet context registers and the pop-pending flag; reset drops any byte in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= 1'b0;
            is_wr_q <= 1'b0;
            addr_q  <= 7'd0;
            cnt_q   <= 8'd0;
        end else begin
            pend_q  <= rx_fifo_rd_en;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, byte demand and bus strobes.
    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        need_byte = 1'b0;
        wr_stb    = 1'b0;
        rd_stb    = 1'b0;
        push_stb  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                need_byte = 1'b1;
                if (byte_vld) begin
                    is_wr_d = rx_fifo_dout[7];
                    addr_d  = rx_fifo_dout[6:0];
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                need_byte = 1'b1;
                if (byte_vld) begin
                    cnt_d = rx_fifo_dout;
                    if (rx_fifo_dout == 8'd0) state_d = ST_AFTER_ZERO;
                    else if (is_wr_q)         state_d = ST_WDATA;
                    else                      state_d = ST_AFTER_RHDR;
                end
            end
            ST_WDATA: begin
                need_byte = 1'b1;
                if (byte_vld) begin
                    wr_stb = 1'b1;
                    addr_d = addr_q + 7'd1;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = ST_AFTER_WR;
                end
            end
            ST_RREQ: begin
                // Only checkpoint for TX space: the single push one cycle later is then safe.
                if (!tx_fifo_full) begin
                    rd_stb  = 1'b1;
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                push_stb = 1'b1;
                addr_d   = addr_q + 7'd1;
                cnt_d    = cnt_q - 8'd1;
                state_d  = (cnt_q == 8'd1) ? ST_IDLE : ST_RREQ;
            end
`ifdef HOST_CMD_CKSUM_EN
            ST_CKSUM: begin
                need_byte = 1'b1;
                if (byte_vld) begin
                    // A bad checksum is only flagged; reads of the packet still go out.
                    state_d = (!is_wr_q && cnt_q != 8'd0) ? ST_RREQ : ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef HOST_CMD_CKSUM_EN
    logic [7:0] cks_q;
    logic       err_q;
    logic       cks_bad;

    assign cks_bad = byte_vld && (state_q == ST_CKSUM) && (rx_fifo_dout != cks_q);

    // Running XOR of CMD, LEN and write data (CMD restarts it); sticky error where a new error beats err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            cks_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            if (byte_vld) begin
                if (state_q == ST_IDLE)
                    cks_q <= rx_fifo_dout;
                else if (state_q == ST_LEN || state_q == ST_WDATA)
                    cks_q <= cks_q ^ rx_fifo_dout;
            end
            if (cks_bad)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    assign err_cksum = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cksum      = 1'b0;
`endif

    // Strobes are held low while reset is asserted so nothing escapes during the reset cycle.
    assign rx_fifo_rd_en = need_byte & ~rx_fifo_empty & ~pend_q & ~reset;
    assign reg_wr_en     = wr_stb & ~reset;
    assign reg_rd_en     = rd_stb & ~reset;
    assign tx_fifo_wr_en = push_stb & ~reset;
    assign reg_addr      = addr_q;
    assign reg_wdata     = reg_wr_en ? rx_fifo_dout : 8'h00;
    assign tx_fifo_din   = tx_fifo_wr_en ? reg_rdata : 8'h00;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/host_cmd_parser.md
# host_cmd_parser

Packet decoder that drains the host SPI receive FIFO and turns host byte streams into register-bus transactions. It returns read data through the host SPI transmit FIFO write port. It sits directly downstream of the host SPI slave's RX FIFO read port and upstream of its TX FIFO. It is the only master on the local 7-bit-address / 8-bit-data register bus.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_fifo_empty  input  1  host RX FIFO empty.
- rx_fifo_rd_en  output  1  pop request to host RX FIFO.
- rx_fifo_dout  input  8  RX FIFO data, valid the cycle after rx_fifo_rd_en.
- tx_fifo_full  input  1  host TX FIFO full.
- tx_fifo_wr_en  output  1  push to host TX FIFO.
- tx_fifo_din  output  8  push data.
- reg_wr_en  output  1  single-cycle register write strobe.
- reg_rd_en  output  1  single-cycle register read strobe.
- reg_addr  output  7  register address.
- reg_wdata  output  8  write data.
- reg_rdata  input  8  read data, valid exactly 1 cycle after reg_rd_en.
- busy  output  1  high whenever state != ST_IDLE.
- err_cksum  output  1  sticky checksum error (macro-dependent).
- err_clr  input  1  clears err_cksum.

## Operation
- Packet format: CMD, LEN, then for writes LEN data bytes, then an optional checksum byte.
  - CMD[7]: 1 = write, 0 = read.
  - CMD[6:0]: start address.
  - LEN: 8 bits; 0 = no transfer.
- Byte fetcher:
  - rx_fifo_rd_en = need_byte & ~rx_fifo_empty & ~pend.
  - pend is set by rd_en and cleared the next cycle.
  - The byte is consumed on the cycle after rd_en (byte_vld).
  - Maximum rate is 1 byte per 2 cycles.
- States:
  - ST_IDLE: need_byte. On byte_vld, latch cmd and addr, go to ST_LEN.
  - ST_LEN: on byte_vld, latch cnt = LEN.
    - LEN=0: go to ST_CKSUM if the macro is defined, else ST_IDLE.
    - Write: go to ST_WDATA.
    - Read: go to ST_CKSUM if the macro is defined, else ST_RREQ.
  - ST_WDATA: on byte_vld, pulse reg_wr_en with reg_addr = addr and reg_wdata = byte. Then addr++ and cnt--. At cnt==1, go to ST_CKSUM (macro) or ST_IDLE.
  - ST_RREQ: when ~tx_fifo_full, pulse reg_rd_en with reg_addr = addr, then go to ST_RWAIT.
  - ST_RWAIT: pulse tx_fifo_wr_en with tx_fifo_din = reg_rdata. Then addr++ and cnt--. Go to ST_IDLE if cnt was 1, else ST_RREQ.
  - ST_CKSUM: on byte_vld, compare and update err_cksum. Then go to ST_RREQ (read with LEN != 0) or ST_IDLE.
- Address wraps modulo 128 (0x7F+1 = 0x00). cnt is an 8-bit counter; LEN=255 gives 255 transfers.
- Writes commit immediately; the checksum cannot cancel them.
- Only one of reg_wr_en and reg_rd_en is ever high in a cycle.

## Timing
- Reset values: rx_fifo_rd_en, tx_fifo_wr_en, reg_wr_en, reg_rd_en, busy, err_cksum = 0. reg_addr, reg_wdata, tx_fifo_din = 0. State = ST_IDLE, pend = 0.
- Reset mid-packet:
  - Return to ST_IDLE next cycle.
  - A byte popped but not yet consumed is discarded.
  - The remainder of the packet is parsed as a new CMD. The host must resynchronise.
- The write strobe occurs on the cycle of byte_vld, i.e. 1 cycle after the rd_en that fetched the byte.
- Read path:
  - reg_rd_en to tx_fifo_wr_en is 1 cycle.
  - Each read byte takes 2 cycles when tx_fifo_full is low.
  - tx_fifo_full is sampled only in ST_RREQ. A push in ST_RWAIT is guaranteed space because full was low one cycle earlier and there is a single writer.
- rx_fifo_empty held high: the state holds indefinitely, with no timeout.
- err_clr and a new error in the same cycle: the error wins, so err_cksum = 1.

## Configuration
- HOST_CMD_CKSUM_EN defined:
  - Every packet carries a trailing checksum byte equal to the XOR of CMD, LEN and all write data bytes.
  - For reads, the checksum follows LEN and is checked before any read is issued.
  - On a mismatch, err_cksum is set. A read packet with a bad checksum still issues its reads.
- HOST_CMD_CKSUM_EN undefined:
  - There is no ST_CKSUM state, and no checksum byte is consumed.
  - err_cksum is tied to 0 and err_clr is ignored.

## Test plan
- Write packet 0x85,0x03,0x11,0x22,0x33 (macro off) -> reg_wr_en pulses three times with (addr,data) = (0x05,0x11), (0x06,0x22), (0x07,0x33). busy falls after the third write.
- Read packet 0x7E,0x03 with reg_rdata = addr+0x40 -> reads at 0x7E, 0x7F, 0x00 (wrap). TX FIFO receives 0xBE, 0xBF, 0x40.
- Read packet 0x10,0x02 with tx_fifo_full held high for 20 cycles -> no reg_rd_en during the stall. Then exactly 2 pushes, each 1 cycle after its reg_rd_en.
- LEN=0 packet 0x90,0x00 followed by 0x81,0x01,0xAA -> no strobes for the first packet. One write of 0xAA to 0x01.
- Macro on: 0x82,0x01,0x5A,0xD9 -> write performed and err_cksum stays 0. Repeat with checksum 0x00 -> write performed and err_cksum = 1. Pulse err_clr -> err_cksum = 0.
- Reset asserted 1 cycle after LEN is consumed in a 4-byte write -> all strobes are 0 the next cycle, state is ST_IDLE, and busy is 0.
